// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a ready handshake and computes the next PC.
// Optional MISALIGN_TRAP_EN: halts on a misaligned next PC instead of forcing word alignment.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ready_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic                  jalr_i,
  input  logic [DATA_WIDTH-1:0] immediate_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [6:0]            op_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
`ifdef MISALIGN_TRAP_EN
  output logic                  misaligned_o,
`endif
  output logic [DATA_WIDTH-1:0] fetch_count_o
);

  localparam logic [DATA_WIDTH-1:0] Nop = 32'h0000_0013;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StFetch, StValid, StHalt} state_e;
  logic misaligned_q, misaligned_d;
`else
  typedef enum logic [1:0] {StFetch, StValid} state_e;
`endif

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] target_raw;
  logic [DATA_WIDTH-1:0] next_pc;

  always_comb begin
    target_raw = pc_q + 32'd4;
    if (jalr_i) begin
      target_raw = (rs1_data_i + immediate_i) & ~32'h1;
    end else if (branch_taken_i) begin
      target_raw = pc_q + immediate_i;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign next_pc = target_raw;
`else
  // Without the trap, misaligned targets are silently word-aligned.
  assign next_pc = {target_raw[DATA_WIDTH-1:2], 2'b00};
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    count_d       = count_q;
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misaligned_d  = misaligned_q;
`endif
    unique case (state_q)
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          instr_d = imem_rdata_i;
          state_d = StValid;
        end
      end
      StValid: begin
        instr_valid_o = 1'b1;
        if (!stall_i) begin
          count_d = count_q + 32'd1;
          pc_d    = next_pc;
          state_d = StFetch;
`ifdef MISALIGN_TRAP_EN
          if (next_pc[1]) begin
            state_d      = StHalt;
            misaligned_d = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
      count_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign instruction_o = instr_q;
  assign op_o          = instr_q[6:0];
  assign fetch_count_o = count_q;
`ifdef MISALIGN_TRAP_EN
  assign misaligned_o  = misaligned_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, stall, branch/JALR targets, wrap and async reset.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic        jalr;
  logic [31:0] immediate;
  logic [31:0] rs1_data;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_count;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ready_i   (imem_ready),
    .imem_rdata_i   (imem_rdata),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .jalr_i         (jalr),
    .immediate_i    (immediate),
    .rs1_data_i     (rs1_data),
    .instr_valid_o  (instr_valid),
    .instruction_o  (instruction),
    .op_o           (op),
    .pc_o           (pc),
    .pc_plus4_o     (pc_plus4),
`ifdef MISALIGN_TRAP_EN
    .misaligned_o   (misaligned),
`endif
    .fetch_count_o  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0;
    branch_taken = 1'b0; jalr = 1'b0; immediate = '0; rs1_data = '0;
    #12;
    check_val("rst_pc", pc, 32'h0040_0000);
    check_val("rst_instr", instruction, 32'h0000_0013);
    check_val("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_val("rst_count", fetch_count, 32'd0);
    check_val("rst_op", {25'b0, op}, 32'h13);

    // Zero-wait fetch
    imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    reset = 1'b1;
    #1;
    check_val("first_req", {31'b0, imem_req}, 32'd1);
    check_val("first_addr", imem_addr, 32'h0040_0000);
    tick();
    check_val("v1_valid", {31'b0, instr_valid}, 32'd1);
    check_val("v1_op", {25'b0, op}, 32'h13);
    check_val("v1_instr", instruction, 32'h0050_0093);
    check_val("v1_req", {31'b0, imem_req}, 32'd0);
    check_val("v1_pc4", pc_plus4, 32'h0040_0004);
    tick();
    check_val("a1_count", fetch_count, 32'd1);
    check_val("a1_addr", imem_addr, 32'h0040_0004);
    check_val("a1_req", {31'b0, imem_req}, 32'd1);
    check_val("a1_valid", {31'b0, instr_valid}, 32'd0);

    // Memory ready delayed 3 cycles
    imem_ready = 1'b0; imem_rdata = 32'h0000_0063;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("wait_req", {31'b0, imem_req}, 32'd1);
      check_val("wait_addr", imem_addr, 32'h0040_0004);
      check_val("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    check_val("late_valid", {31'b0, instr_valid}, 32'd1);
    imem_ready = 1'b0;

    // Stall in VALID for 4 cycles
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("stall_instr", instruction, 32'h0000_0063);
      check_val("stall_pc", pc, 32'h0040_0004);
      check_val("stall_count", fetch_count, 32'd1);
      check_val("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check_val("unstall_count", fetch_count, 32'd2);
    check_val("unstall_pc", pc, 32'h0040_0008);

    // Two sequential fetches to reach 0x0040_0010
    imem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check_val("seq_pc", pc, 32'h0040_0010);
    check_val("seq_count", fetch_count, 32'd4);
    tick();
    branch_taken = 1'b1; immediate = 32'hFFFF_FFF8;
    tick();
    check_val("br_addr", imem_addr, 32'h0040_0008);
    check_val("br_count", fetch_count, 32'd5);
    branch_taken = 1'b0;

    // JALR has priority over branch
    tick();
    jalr = 1'b1; branch_taken = 1'b1; rs1_data = 32'h0040_0101; immediate = 32'd4;
    tick();
    check_val("jalr_addr", imem_addr, 32'h0040_0104);
    check_val("jalr_count", fetch_count, 32'd6);
    branch_taken = 1'b0;

    // PC wrap at the top of the address space
    tick();
    rs1_data = 32'hFFFF_FFF0; immediate = 32'h0000_000C;
    tick();
    check_val("top_pc", pc, 32'hFFFF_FFFC);
    check_val("wrap_pc4", pc_plus4, 32'h0000_0000);
    jalr = 1'b0;
    tick(); tick();
    check_val("wrap_addr", imem_addr, 32'h0000_0000);
    check_val("wrap_count", fetch_count, 32'd8);

    // Misaligned branch target (pc 0 + 6)
    tick();
    branch_taken = 1'b1; immediate = 32'd6; imem_ready = 1'b0;
    tick();
    branch_taken = 1'b0;
    check_val("mis_count", fetch_count, 32'd9);
`ifdef MISALIGN_TRAP_EN
    check_val("mis_pc", pc, 32'h0000_0006);
    check_val("mis_flag", {31'b0, misaligned}, 32'd1);
    imem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_val("halt_req", {31'b0, imem_req}, 32'd0);
      check_val("halt_valid", {31'b0, instr_valid}, 32'd0);
      tick();
    end
    imem_ready = 1'b0;
`else
    check_val("align_addr", imem_addr, 32'h0000_0004);
    tick();
    check_val("pend_req", {31'b0, imem_req}, 32'd1);
`endif

    // Asynchronous reset while a fetch is waiting
    #3;
    reset = 1'b0;
    #1;
    check_val("arst_pc", pc, 32'h0040_0000);
    check_val("arst_count", fetch_count, 32'd0);
    check_val("arst_valid", {31'b0, instr_valid}, 32'd0);
    check_val("arst_instr", instruction, 32'h0000_0013);
`ifdef MISALIGN_TRAP_EN
    check_val("arst_flag", {31'b0, misaligned}, 32'd0);
`endif
    tick();
    reset = 1'b1;
    tick();
    check_val("rel_req", {31'b0, imem_req}, 32'd1);
    check_val("rel_addr", imem_addr, 32'h0040_0000);
    check_val("rel_valid", {31'b0, instr_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
